// File: rtl/sic_pkg.sv
// Shared types for the register-file sequencer: FSM states, the latched
// instruction record and the source-skip rule.
package sic_pkg;

  localparam int SIC_NUM_PHY_REGS = 32;
  localparam int SIC_ADDR_W       = $clog2(SIC_NUM_PHY_REGS);
  localparam int SIC_ID_W         = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD0,
    S_REL0,
    S_RD1,
    S_REL1,
    S_EXEC,
    S_WAIT_RES,
    S_WR,
    S_WREL
  } sic_state_e;

  typedef struct packed {
    logic [SIC_ID_W-1:0]   issue_id;
    logic [SIC_ADDR_W-1:0] src0;
    logic [SIC_ADDR_W-1:0] src1;
    logic [SIC_ADDR_W-1:0] dst;
    logic                  use_src0;
    logic                  use_src1;
    logic                  use_dst;
  } sic_instr_t;

  // A source needs a register-file read unless unused or hard-wired zero.
  function automatic logic needs_src(input logic                  use_f,
                                     input logic [SIC_ADDR_W-1:0] addr,
                                     input logic                  zero_en);
    return use_f && !(zero_en && (addr == '0));
  endfunction

endpackage

// File: rtl/sic_reg_sequencer.sv
// Per-instruction controller that serialises src0/src1 reads, the execute
// handshake and the destination write through one locking register-file port.
module sic_reg_sequencer
  import sic_pkg::*;
#(
  parameter int NUM_PHY_REGS = SIC_NUM_PHY_REGS,
  parameter int ID_WIDTH     = SIC_ID_W,
  parameter int ZERO_REG_EN  = 1,
  localparam int ADDR_W      = $clog2(NUM_PHY_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                disp_valid,
  output logic                disp_ready,
  input  logic [ID_WIDTH-1:0] disp_issue_id,
  input  logic [ADDR_W-1:0]   disp_src0,
  input  logic [ADDR_W-1:0]   disp_src1,
  input  logic [ADDR_W-1:0]   disp_dst,
  input  logic                disp_use_src0,
  input  logic                disp_use_src1,
  input  logic                disp_use_dst,
  input  logic                flush,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic                reg_req_read,
  output logic                reg_req_write,
  output logic                reg_release,
  output logic [ID_WIDTH-1:0] reg_issue_id,
  output logic [31:0]         reg_wdata,
  input  logic [31:0]         reg_rdata,
  input  logic                reg_grant,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [31:0]         ex_op0,
  output logic [31:0]         ex_op1,
  output logic [ID_WIDTH-1:0] ex_issue_id,
  input  logic                res_valid,
  input  logic [31:0]         res_data,
  output logic                done,
  output logic [ID_WIDTH-1:0] done_issue_id
);

  localparam logic ZeroEn = (ZERO_REG_EN != 0);

  sic_state_e r_state;
  sic_state_e w_nextState;
  sic_instr_t r_instr;
  logic [31:0] r_op0;
  logic [31:0] r_op1;
  logic [31:0] r_result;
  logic        r_done;
  logic        w_accept;
  logic        w_doneNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Flush aborts everywhere except WREL, where the write is already committing.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_doneNext  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (disp_valid && !flush) begin
          w_accept = 1'b1;
          if (needs_src(disp_use_src0, disp_src0, ZeroEn)) begin
            w_nextState = S_RD0;
          end else if (needs_src(disp_use_src1, disp_src1, ZeroEn)) begin
            w_nextState = S_RD1;
          end else begin
            w_nextState = S_EXEC;
          end
        end
      end
      S_RD0: begin
        if (flush) w_nextState = S_IDLE;
        else if (reg_grant) w_nextState = S_REL0;
      end
      S_REL0: begin
        if (flush) w_nextState = S_IDLE;
        else if (needs_src(r_instr.use_src1, r_instr.src1, ZeroEn)) w_nextState = S_RD1;
        else w_nextState = S_EXEC;
      end
      S_RD1: begin
        if (flush) w_nextState = S_IDLE;
        else if (reg_grant) w_nextState = S_REL1;
      end
      S_REL1: begin
        w_nextState = flush ? S_IDLE : S_EXEC;
      end
      S_EXEC: begin
        if (flush) w_nextState = S_IDLE;
        else if (ex_ready) w_nextState = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (flush) begin
          w_nextState = S_IDLE;
        end else if (res_valid) begin
          w_nextState = r_instr.use_dst ? S_WR : S_IDLE;
          w_doneNext  = !r_instr.use_dst;
        end
      end
      S_WR: begin
        if (flush) w_nextState = S_IDLE;
        else if (reg_grant) w_nextState = S_WREL;
      end
      S_WREL: begin
        w_nextState = S_IDLE;
        w_doneNext  = 1'b1;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Operands restart at zero on dispatch so skipped sources read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr  <= '0;
      r_op0    <= '0;
      r_op1    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_doneNext;
      if (w_accept) begin
        r_instr <= '{issue_id: disp_issue_id, src0: disp_src0, src1: disp_src1,
                     dst: disp_dst, use_src0: disp_use_src0,
                     use_src1: disp_use_src1, use_dst: disp_use_dst};
        r_op0   <= '0;
        r_op1   <= '0;
      end
      if (r_state == S_RD0 && reg_grant && !flush) r_op0 <= reg_rdata;
      if (r_state == S_RD1 && reg_grant && !flush) r_op1 <= reg_rdata;
      if (r_state == S_WAIT_RES && res_valid && !flush) r_result <= res_data;
    end
  end

  always_comb begin
    disp_ready    = (r_state == S_IDLE);
    reg_addr      = '0;
    reg_req_read  = 1'b0;
    reg_req_write = 1'b0;
    reg_release   = 1'b0;
    reg_wdata     = '0;
    ex_valid      = (r_state == S_EXEC);
    case (r_state)
      S_RD0:  begin reg_addr = r_instr.src0; reg_req_read = 1'b1; end
      S_REL0: begin reg_addr = r_instr.src0; reg_release  = 1'b1; end
      S_RD1:  begin reg_addr = r_instr.src1; reg_req_read = 1'b1; end
      S_REL1: begin reg_addr = r_instr.src1; reg_release  = 1'b1; end
      S_WR: begin
        reg_addr      = r_instr.dst;
        reg_req_write = 1'b1;
        reg_wdata     = r_result;
      end
      S_WREL: begin
        reg_addr      = r_instr.dst;
        reg_req_write = 1'b1;
        reg_release   = 1'b1;
        reg_wdata     = r_result;
      end
      default: ;
    endcase
  end

  assign reg_issue_id  = (r_state == S_IDLE) ? '0 : r_instr.issue_id;
  assign ex_op0        = r_op0;
  assign ex_op1        = r_op1;
  assign ex_issue_id   = r_instr.issue_id;
  assign done          = r_done;
  assign done_issue_id = r_done ? r_instr.issue_id : '0;

endmodule

// File: tb/tb_sic_reg_sequencer.sv
// Directed bench: builds a cycle-by-cycle expected timeline from phase
// durations and checks every DUT output against it each cycle.
module tb_sic_reg_sequencer;

  localparam int AW = 5;
  localparam int IW = 4;
  localparam int TL = 64;
  localparam int PH_IDLE = 0, PH_RD = 1, PH_REL = 2, PH_EX = 3;
  localparam int PH_WAIT = 4, PH_WR = 5, PH_WREL = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          disp_valid = 1'b0;
  logic          disp_ready;
  logic [IW-1:0] disp_issue_id = '0;
  logic [AW-1:0] disp_src0 = '0, disp_src1 = '0, disp_dst = '0;
  logic          disp_use_src0 = 1'b0, disp_use_src1 = 1'b0, disp_use_dst = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] reg_addr;
  logic          reg_req_read, reg_req_write, reg_release;
  logic [IW-1:0] reg_issue_id;
  logic [31:0]   reg_wdata;
  logic [31:0]   reg_rdata = '0;
  logic          reg_grant = 1'b0;
  logic          ex_valid;
  logic          ex_ready = 1'b0;
  logic [31:0]   ex_op0, ex_op1;
  logic [IW-1:0] ex_issue_id;
  logic          res_valid = 1'b0;
  logic [31:0]   res_data = '0;
  logic          done;
  logic [IW-1:0] done_issue_id;

  always #5 clk = ~clk;

  sic_reg_sequencer #(.NUM_PHY_REGS(32), .ID_WIDTH(IW), .ZERO_REG_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_issue_id(disp_issue_id),
    .disp_src0(disp_src0), .disp_src1(disp_src1), .disp_dst(disp_dst),
    .disp_use_src0(disp_use_src0), .disp_use_src1(disp_use_src1), .disp_use_dst(disp_use_dst),
    .flush(flush),
    .reg_addr(reg_addr), .reg_req_read(reg_req_read), .reg_req_write(reg_req_write),
    .reg_release(reg_release), .reg_issue_id(reg_issue_id), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_grant(reg_grant),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op0(ex_op0), .ex_op1(ex_op1),
    .ex_issue_id(ex_issue_id), .res_valid(res_valid), .res_data(res_data),
    .done(done), .done_issue_id(done_issue_id)
  );

  typedef struct {
    logic dispReady, regRead, regWrite, regRel, exValid, done;
    logic [AW-1:0] regAddr;
    logic [IW-1:0] regId, exId, doneId;
    logic [31:0] wdata, op0, op1;
  } expT;

  typedef struct {
    logic grant, exReady, resValid, flush, rst;
    logic [31:0] rdata, resData;
  } stimT;

  expT  expTl[TL];
  stimT stimTl[TL];
  int   phaseOf[TL];
  int   tlLen, t, cyc;
  logic active = 1'b0;
  int   checks = 0, errors = 0;
  logic [IW-1:0] curId;
  logic [AW-1:0] curS0, curS1, curD;
  logic curU0, curU1, curUd;
  int   obsReads, obsRels, obsWrites, obsCommits, obsDones, obsDoneCycle, obsExFirst;
  logic [31:0] obsOp0, obsOp1;

  function automatic expT idleExp();
    expT e;
    e.dispReady = 1'b1; e.regRead = 1'b0; e.regWrite = 1'b0; e.regRel = 1'b0;
    e.exValid = 1'b0; e.done = 1'b0; e.regAddr = '0; e.regId = '0;
    e.exId = '0; e.doneId = '0; e.wdata = '0; e.op0 = '0; e.op1 = '0;
    return e;
  endfunction

  function automatic stimT idleStim();
    stimT s;
    s.grant = 1'b0; s.exReady = 1'b0; s.resValid = 1'b0; s.flush = 1'b0;
    s.rst = 1'b0; s.rdata = 32'hBAD0_BAD0; s.resData = 32'h0BAD_0BAD;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  // One phase of the instruction: len cycles, handshake input on the last one.
  task automatic addPhase(input int kind, input int len, input logic [AW-1:0] addr,
                          input logic [31:0] v0, input logic [31:0] v1);
    expT e;
    for (int k = 0; k < len; k++) begin
      e = idleExp();
      e.dispReady = 1'b0;
      e.regId = curId;
      case (kind)
        PH_RD:   begin e.regRead = 1'b1; e.regAddr = addr; end
        PH_REL:  begin e.regRel = 1'b1; e.regAddr = addr; end
        PH_EX:   begin e.exValid = 1'b1; e.op0 = v0; e.op1 = v1; e.exId = curId; end
        PH_WR:   begin e.regWrite = 1'b1; e.regAddr = addr; e.wdata = v0; end
        PH_WREL: begin e.regWrite = 1'b1; e.regRel = 1'b1; e.regAddr = addr; e.wdata = v0; end
        default: ;
      endcase
      expTl[t] = e;
      phaseOf[t] = kind;
      if (k == len - 1) begin
        case (kind)
          PH_RD:   begin stimTl[t].grant = 1'b1; stimTl[t].rdata = v0; end
          PH_EX:   stimTl[t].exReady = 1'b1;
          PH_WAIT: begin stimTl[t].resValid = 1'b1; stimTl[t].resData = v0; end
          PH_WR:   stimTl[t].grant = 1'b1;
          default: ;
        endcase
      end
      t++;
    end
  endtask

  task automatic cutAfter(input int f);
    for (int c = f + 1; c < TL; c++) begin
      expTl[c] = idleExp();
      stimTl[c] = idleStim();
      phaseOf[c] = PH_IDLE;
    end
    tlLen = f + 5;
  endtask

  task automatic buildScenario(input logic [IW-1:0] id, input logic [AW-1:0] s0, s1, d,
                               input logic u0, u1, ud, input logic [31:0] v0, v1, res,
                               input int g0, g1, gw, er, rv, flushAt, rstAt);
    logic need0, need1;
    int doneCycle;
    curId = id; curS0 = s0; curS1 = s1; curD = d;
    curU0 = u0; curU1 = u1; curUd = ud;
    for (int c = 0; c < TL; c++) begin
      expTl[c] = idleExp(); stimTl[c] = idleStim(); phaseOf[c] = PH_IDLE;
    end
    need0 = u0 && (s0 != 0);
    need1 = u1 && (s1 != 0);
    t = 1;
    if (need0) begin addPhase(PH_RD, g0 + 1, s0, v0, 0); addPhase(PH_REL, 1, s0, 0, 0); end
    if (need1) begin addPhase(PH_RD, g1 + 1, s1, v1, 0); addPhase(PH_REL, 1, s1, 0, 0); end
    addPhase(PH_EX, er + 1, 0, need0 ? v0 : 32'h0, need1 ? v1 : 32'h0);
    addPhase(PH_WAIT, rv + 1, 0, res, 0);
    if (ud) begin addPhase(PH_WR, gw + 1, d, res, 0); addPhase(PH_WREL, 1, d, res, 0); end
    doneCycle = t;
    expTl[doneCycle].done = 1'b1;
    expTl[doneCycle].doneId = id;
    tlLen = doneCycle + 4;
    if (flushAt >= 0) begin
      if (flushAt < doneCycle && phaseOf[flushAt] != PH_WREL) cutAfter(flushAt);
      stimTl[flushAt].flush = 1'b1;
    end
    if (rstAt > 0) begin
      cutAfter(rstAt - 1);
      stimTl[rstAt].rst = 1'b1;
    end
  endtask

  task automatic applyStimulus();
    obsReads = 0; obsRels = 0; obsWrites = 0; obsCommits = 0; obsDones = 0;
    obsDoneCycle = -1; obsExFirst = -1; obsOp0 = 32'hFFFF_FFFF; obsOp1 = 32'hFFFF_FFFF;
    for (int c = 0; c < tlLen; c++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = c;
      active = 1'b1;
      disp_valid = (c == 0);
      disp_issue_id = curId; disp_src0 = curS0; disp_src1 = curS1; disp_dst = curD;
      disp_use_src0 = curU0; disp_use_src1 = curU1; disp_use_dst = curUd;
      reg_grant = stimTl[c].grant; reg_rdata = stimTl[c].rdata;
      ex_ready = stimTl[c].exReady; res_valid = stimTl[c].resValid;
      res_data = stimTl[c].resData; flush = stimTl[c].flush;
      if (stimTl[c].rst) begin
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_req_write", reg_req_write, 0);
        checkOutput("async_rst_wdata", reg_wdata, 0);
        checkOutput("async_rst_addr", reg_addr, 0);
        checkOutput("async_rst_ex_op0", ex_op0, 0);
      end
    end
    @(posedge clk);
    #1;
    active = 1'b0;
    rst_n = 1'b1;
    disp_valid = 1'b0; reg_grant = 1'b0; ex_ready = 1'b0; res_valid = 1'b0; flush = 1'b0;
  endtask

  always @(negedge clk) begin
    if (active) begin
      checkOutput("disp_ready", disp_ready, expTl[cyc].dispReady);
      checkOutput("reg_req_read", reg_req_read, expTl[cyc].regRead);
      checkOutput("reg_req_write", reg_req_write, expTl[cyc].regWrite);
      checkOutput("reg_release", reg_release, expTl[cyc].regRel);
      checkOutput("ex_valid", ex_valid, expTl[cyc].exValid);
      checkOutput("done", done, expTl[cyc].done);
      checkOutput("reg_issue_id", reg_issue_id, expTl[cyc].regId);
      if (expTl[cyc].regRead || expTl[cyc].regWrite || expTl[cyc].regRel)
        checkOutput("reg_addr", reg_addr, expTl[cyc].regAddr);
      if (expTl[cyc].regWrite) checkOutput("reg_wdata", reg_wdata, expTl[cyc].wdata);
      if (expTl[cyc].exValid) begin
        checkOutput("ex_op0", ex_op0, expTl[cyc].op0);
        checkOutput("ex_op1", ex_op1, expTl[cyc].op1);
        checkOutput("ex_issue_id", ex_issue_id, expTl[cyc].exId);
      end
      if (expTl[cyc].done) checkOutput("done_issue_id", done_issue_id, expTl[cyc].doneId);
      if (reg_req_read) obsReads++;
      if (reg_release) obsRels++;
      if (reg_req_write) obsWrites++;
      if (reg_req_write && reg_release) obsCommits++;
      if (done) begin obsDones++; obsDoneCycle = cyc; end
      if (ex_valid) begin
        if (obsExFirst < 0) obsExFirst = cyc;
        obsOp0 = ex_op0;
        obsOp1 = ex_op1;
      end
    end
  end

  initial begin
    cyc = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_disp_ready", disp_ready, 1);
    checkOutput("reset_req_read", reg_req_read, 0);
    checkOutput("reset_ex_valid", ex_valid, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_reg_addr", reg_addr, 0);
    checkOutput("reset_ex_op0", ex_op0, 0);
    checkOutput("reset_reg_issue_id", reg_issue_id, 0);
    rst_n = 1'b1;

    // Full two-read + write instruction at minimum latency.
    buildScenario(3, 5, 6, 7, 1, 1, 1, 32'h11, 32'h22, 32'h33, 0, 0, 0, 0, 0, -1, -1);
    applyStimulus();
    checkOutput("t1_done_cycle", obsDoneCycle, 9);
    checkOutput("t1_releases", obsRels, 3);
    checkOutput("t1_commits", obsCommits, 1);
    checkOutput("t1_op0", obsOp0, 32'h11);
    checkOutput("t1_op1", obsOp1, 32'h22);

    // Zero-register and unused source, no destination.
    buildScenario(5, 0, 4, 8, 1, 0, 0, 32'h99, 32'h77, 32'h44, 0, 0, 0, 0, 0, -1, -1);
    applyStimulus();
    checkOutput("t2_ex_first", obsExFirst, 1);
    checkOutput("t2_reads", obsReads, 0);
    checkOutput("t2_op0", obsOp0, 0);
    checkOutput("t2_op1", obsOp1, 0);
    checkOutput("t2_done_cycle", obsDoneCycle, 3);

    // Grant withheld ten cycles in RD0.
    buildScenario(7, 12, 0, 0, 1, 0, 0, 32'hDEAD, 0, 32'h5, 10, 0, 0, 0, 0, -1, -1);
    applyStimulus();
    checkOutput("t3_reads", obsReads, 11);
    checkOutput("t3_releases", obsRels, 1);
    checkOutput("t3_op0", obsOp0, 32'hDEAD);
    checkOutput("t3_done_cycle", obsDoneCycle, 15);

    // Flush in WAIT_RES together with res_valid.
    buildScenario(9, 5, 6, 7, 1, 1, 1, 32'h11, 32'h22, 32'h33, 0, 0, 0, 0, 0, 6, -1);
    applyStimulus();
    checkOutput("t4_dones", obsDones, 0);
    checkOutput("t4_writes", obsWrites, 0);

    // Asynchronous reset while waiting for a write grant.
    buildScenario(10, 5, 6, 7, 1, 1, 1, 32'h11, 32'h22, 32'h33, 0, 0, 3, 0, 0, -1, 8);
    applyStimulus();
    checkOutput("t5_commits", obsCommits, 0);
    checkOutput("t5_dones", obsDones, 0);

    // No destination, zero src1, delayed result.
    buildScenario(11, 9, 0, 3, 1, 1, 0, 32'h55, 32'h0, 32'h66, 0, 0, 0, 0, 2, -1, -1);
    applyStimulus();
    checkOutput("t6_done_cycle", obsDoneCycle, 7);
    checkOutput("t6_writes", obsWrites, 0);
    checkOutput("t6_reads", obsReads, 1);

    // Flush during REL0: release completes, then idle.
    buildScenario(12, 5, 6, 7, 1, 1, 1, 32'h11, 32'h22, 32'h33, 0, 0, 0, 0, 0, 2, -1);
    applyStimulus();
    checkOutput("t7_releases", obsRels, 1);
    checkOutput("t7_dones", obsDones, 0);

    // Flush during WREL: the write still commits and done still pulses.
    buildScenario(13, 5, 6, 7, 1, 1, 1, 32'h11, 32'h22, 32'h33, 0, 0, 0, 0, 0, 8, -1);
    applyStimulus();
    checkOutput("t8_done_cycle", obsDoneCycle, 9);
    checkOutput("t8_commits", obsCommits, 1);

    // Flush coinciding with the RD1 grant: the grant is not consumed.
    buildScenario(14, 5, 6, 7, 1, 1, 1, 32'h11, 32'h22, 32'h33, 0, 0, 0, 0, 0, 3, -1);
    applyStimulus();
    checkOutput("t9_releases", obsRels, 1);
    checkOutput("t9_dones", obsDones, 0);

    // Dispatch ignored while flush is high in IDLE.
    buildScenario(15, 5, 6, 7, 1, 1, 1, 32'h11, 32'h22, 32'h33, 0, 0, 0, 0, 0, 0, -1);
    applyStimulus();
    checkOutput("t10_reads", obsReads, 0);
    checkOutput("t10_ex_first", obsExFirst, -1);

    // Mixed stalls on every handshake.
    buildScenario(6, 20, 21, 22, 1, 1, 1, 32'hA5A5_0001, 32'h5A5A_0002, 32'hCAFE_F00D,
                  1, 2, 2, 3, 1, -1, -1);
    applyStimulus();
    checkOutput("t11_done_cycle", obsDoneCycle, 18);
    checkOutput("t11_reads", obsReads, 5);
    checkOutput("t11_writes", obsWrites, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sic_reg_sequencer.md
Name: sic_reg_sequencer

Overview:
- Per-instruction controller that owns one port of the locking physical register file.
- Accepts one dispatched instruction and serialises access through its single register-file port: acquire/read src0, acquire/read src1, hand operands to the execute unit, acquire dst, write the result, release.
- NUM_SICS instances sit upstream of the register file, one per port, between dispatch and execute.

Parameters:
- NUM_PHY_REGS, 32, physical register count; ADDR_W = $clog2(NUM_PHY_REGS).
- ID_WIDTH, 4, issue-id width.
- ZERO_REG_EN, 1, when 1 a source address of 0 is read as 32'h0 without any register-file access.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- disp_valid  in  1  dispatch request valid.
- disp_ready  out  1  high only in IDLE.
- disp_issue_id  in  ID_WIDTH  issue sequence id.
- disp_src0, disp_src1, disp_dst  in  ADDR_W each  register addresses.
- disp_use_src0, disp_use_src1, disp_use_dst  in  1 each  operand enables.
- flush  in  1  abort the current instruction.
- reg_addr  out  ADDR_W  register-file port address.
- reg_req_read, reg_req_write, reg_release  out  1 each  register-file requests.
- reg_issue_id  out  ID_WIDTH  latched issue id.
- reg_wdata  out  32  write data.
- reg_rdata  in  32  read data, valid only when granted with reg_req_read high.
- reg_grant  in  1  lock grant for the current address.
- ex_valid  out  1  operands valid to execute.
- ex_ready  in  1  execute accepts operands.
- ex_op0, ex_op1  out  32  operand values.
- ex_issue_id  out  ID_WIDTH  latched issue id.
- res_valid  in  1  execute result valid.
- res_data  in  32  execute result.
- done  out  1  one-cycle completion pulse.
- done_issue_id  out  ID_WIDTH  id of the completing instruction.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All request, valid and done outputs are 0; reg_addr, reg_wdata, ex_op0/1 and the ids are 0.
  - Latched operands are cleared.
  - Deasserting reset mid-operation never resumes the old instruction.
- Outputs are Moore-style, decoded from state and registered fields only. Inputs are sampled on the rising edge.
- States: IDLE, RD0, REL0, RD1, REL1, EXEC, WAIT_RES, WR, WREL.
- IDLE:
  - disp_ready=1.
  - On disp_valid, latch all disp_* fields and go to the first needed state, in the order RD0, RD1, EXEC.
  - A source is skipped when its use flag is 0, or when ZERO_REG_EN=1 and its address is 0. A skipped source yields operand 32'h0.
- RD0:
  - Drives reg_addr=src0 and reg_req_read=1 until a cycle with reg_grant=1.
  - On that cycle, capture reg_rdata into op0 and go to REL0.
- REL0:
  - Drives reg_addr=src0, reg_release=1 and reg_req_read=0 for exactly 1 cycle.
  - Next state is RD1 if src1 is needed, otherwise EXEC.
- RD1 / REL1: identical to RD0 / REL0 using src1 and op1; REL1 always goes to EXEC.
- EXEC:
  - Drives ex_valid=1 with op0, op1 and issue_id held stable until ex_ready=1.
  - On the handshake cycle go to WAIT_RES.
- WAIT_RES:
  - On res_valid, latch res_data.
  - Go to WR if use_dst=1; otherwise pulse done next cycle and go to IDLE.
- WR:
  - Drives reg_addr=dst, reg_req_write=1 and reg_wdata=result until reg_grant=1, then go to WREL.
- WREL:
  - Drives reg_addr=dst, reg_req_write=1, reg_wdata=result and reg_release=1 for 1 cycle. The write commits on this cycle.
  - Then go to IDLE and pulse done.
- done:
  - Pulses in the cycle after the final state, i.e. the first IDLE cycle, together with done_issue_id.
  - A new dispatch may be accepted in that same cycle.
- reg_issue_id always equals the latched issue id outside IDLE, and 0 in IDLE.
- flush:
  - In IDLE, flush has no effect, and disp_valid is ignored while flush=1.
  - In RD0, RD1, EXEC, WAIT_RES or WR, the next state is IDLE and no request is asserted in that next cycle. No lock is held in these states, so nothing is released.
  - In REL0 or REL1, the release completes, then IDLE follows.
  - In WREL, the write commits and done still pulses.
  - A flushed instruction never pulses done.
- Simultaneous events:
  - res_valid in WAIT_RES together with flush: flush wins and the result is dropped.
  - reg_grant arriving in the same cycle as flush in RD or WR states: flush wins, and the grant is not consumed.
- No timeouts: a wait for reg_grant or ex_ready may last indefinitely.
- Minimum latency:
  - Two reads plus a write, all immediate grants and ready execute with res_valid one cycle after ex_ready: dispatch at cycle 0, done at cycle 9.

Decomposition:
- Package sic_pkg holds:
  - typedef sic_state_e, the enum of the 9 states;
  - typedef sic_instr_t, a packed struct of issue_id, src0/src1/dst and the three use flags;
  - function needs_src(use, addr) implementing the skip rule.
- One module and no sub-module; the FSM and latches are naturally single-level.

Test Plan:
- Dispatch id=3, src0=5 (holds 0x11), src1=6 (holds 0x22), dst=7, grants immediate, result 0x33 -> reg_release at cycles 2 and 4, ex_op0=0x11 and ex_op1=0x22, write of 0x33 on cycle 8, done with done_issue_id=3 at cycle 9.
- src0=0, use_src1=0, ZERO_REG_EN=1 -> no reg_req_read ever asserted, ex_valid high at cycle 1 with ex_op0=0 and ex_op1=0.
- reg_grant withheld for 10 cycles in RD0, then reg_rdata=0xDEAD -> reg_req_read held for 11 cycles, op0=0xDEAD, exactly one release cycle.
- flush during WAIT_RES, with res_valid asserted in the same cycle -> IDLE next cycle, no write, no done, disp_ready=1.
- rst_n pulled low during WR -> outputs 0 immediately (async); after release, disp_ready=1 and no write occurs.
- use_dst=0 -> no reg_req_write; done pulses the cycle after res_valid.
